step_sequencer: RTL and testbench

Autonomous pattern player that drives the register-write port of the signal generator (write_strobe / address / data) so a melody plays without an external controller. It holds an 8-entry pattern memory loaded from the pins. At a programmable tempo it emits a two-write burst per step: channel A period low bits, then channel A volume. It sits directly upstream of the signal generator and shares its clock.

---
 rtl/step_sequencer.sv | 138 +++++++++++++
 tb/tb_step_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Autonomous 8-step pattern player feeding the signal generator's register-write port.
// Each step emits a NOTE write (period A) then a VOL write (volume A), then waits out the tempo.
module step_sequencer #(
  parameter int TICK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] tempo,
  input  logic [3:0] vol_level,
  input  logic       load_en,
  input  logic [2:0] load_addr,
  input  logic [7:0] load_data,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic [2:0] step,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // write_strobe is a one-cycle qualifier for address/data; the receiver has no back-pressure.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NOTE = 3'd1,
    S_VOL  = 3'd2,
    S_WAIT = 3'd3,
    S_MUTE = 3'd4
  } state_t;

  localparam int CW = $clog2(256 * TICK_DIV) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_mem [8];
  logic [7:0]    r_entry;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_step;
  logic          r_stop;
  logic          r_strobe;
  logic [2:0]    r_addr;
  logic [4:0]    r_data;
  logic          r_busy;

  logic          w_expire;
  logic [2:0]    w_step_next;
  logic [CW-1:0] w_load;
  logic [4:0]    w_vol;

  // WAIT spans (tempo+1)*TICK_DIV-2 cycles; counting down to zero inclusive needs a load of N-3.
  assign w_load      = CW'((int'(tempo) + 1) * TICK_DIV - 3);
  assign w_expire    = (r_cnt == '0);
  assign w_step_next = (r_entry[1] || r_step == 3'd7) ? 3'd0 : r_step + 3'd1;

  always_comb begin
    w_vol = {1'b0, vol_level};
    if (!r_entry[7])
      w_vol = 5'd0;
    else if (r_entry[0])
      w_vol = 5'h0F;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run) w_next = S_NOTE;
      S_NOTE:  w_next = S_VOL;
      S_VOL:   w_next = (!run || r_stop) ? S_MUTE : S_WAIT;
      S_WAIT: begin
        if (!run)
          w_next = S_MUTE;
        else if (w_expire)
          w_next = S_NOTE;
      end
      S_MUTE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_entry  <= 8'd0;
      r_cnt    <= '0;
      r_step   <= 3'd0;
      r_stop   <= 1'b0;
      r_strobe <= 1'b0;
      r_addr   <= 3'd0;
      r_data   <= 5'd0;
      r_busy   <= 1'b0;
      for (int i = 0; i < 8; i++) r_mem[i] <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_strobe <= 1'b0;
      r_busy   <= (r_state != S_IDLE);
      if (load_en) r_mem[load_addr] <= load_data;
      case (r_state)
        S_IDLE: if (run) r_entry <= r_mem[r_step];
        S_NOTE: begin
          r_strobe <= 1'b1;
          r_addr   <= 3'd0;
          r_data   <= r_entry[6:2];
          r_stop   <= !run;
        end
        S_VOL: begin
          r_strobe <= 1'b1;
          r_addr   <= 3'd2;
          r_data   <= w_vol;
          r_cnt    <= w_load;
        end
        S_WAIT: begin
          if (run && w_expire) begin
            r_step  <= w_step_next;
            r_entry <= r_mem[w_step_next];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_MUTE: begin
          r_strobe <= 1'b1;
          r_addr   <= 3'd2;
          r_data   <= 5'd0;
          r_step   <= 3'd0;
          r_stop   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign write_strobe = r_strobe;
  assign address      = r_addr;
  assign data         = r_data;
  assign step         = r_step;
  assign busy         = r_busy;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: every strobe is logged with its cycle and compared
// against a hand-built expected list.
module tb_step_sequencer;
  localparam int W = 27;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [7:0] tempo = 8'd1;
  logic [3:0] vol_level = 4'd8;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = 3'd0;
  logic [7:0] load_data = 8'd0;
  logic       write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic [2:0] step;
  logic       busy;
  logic [2:0] dbg_state;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int base;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  step_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .tempo(tempo), .vol_level(vol_level),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .write_strobe(write_strobe), .address(address), .data(data),
    .step(step), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe logger: {cycle, address, data, step}
  always @(posedge clk) begin
    #1;
    if (write_strobe === 1'b1)
      obs_q.push_back({16'(cyc), address, data, step});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    at(cyc + 1);
    load_en   = 1'b0;
  endtask

  task automatic exp_wr(input int c, input int a, input int d, input int s);
    exp_q.push_back({16'(c), 3'(a), 5'(d), 3'(s)});
  endtask

  // scoreboard
  task automatic check_log(input string tag);
    int n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // reset, then idle
    at(3);
    chk("rst_strobe", 32'(write_strobe), 32'd0);
    chk("rst_addr",   32'(address), 32'd0);
    chk("rst_data",   32'(data), 32'd0);
    chk("rst_step",   32'(step), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_state",  32'(dbg_state), 32'd0);
    rst = 1'b1;
    at(cyc + 100);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_step", 32'(step), 32'd0);
    check_log("idle");

    // basic play, then stop in WAIT
    load(3'd0, 8'h84);
    load(3'd1, 8'h8B);
    tempo = 8'd1; vol_level = 4'd8;
    base = cyc;
    run = 1'b1;
    exp_wr(base + 2, 0, 1, 0);   exp_wr(base + 3, 2, 8, 0);
    exp_wr(base + 10, 0, 2, 1);  exp_wr(base + 11, 2, 15, 1);
    exp_wr(base + 18, 0, 1, 0);  exp_wr(base + 19, 2, 8, 0);
    exp_wr(base + 24, 2, 0, 0);
    at(base + 22);
    run = 1'b0;
    at(base + 25);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_step", 32'(step), 32'd0);
    at(base + 45);
    check_log("basic");

    // full wrap: no last bits, odd entries ungated
    for (int i = 0; i < 8; i++)
      load(3'(i), {(i % 2 == 0) ? 1'b1 : 1'b0, 5'(i + 3), 2'b00});
    vol_level = 4'd5;
    base = cyc;
    run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_wr(base + 2 + 8 * k, 0, (k % 8) + 3, k % 8);
      exp_wr(base + 3 + 8 * k, 2, ((k % 8) % 2 == 0) ? 5 : 0, k % 8);
    end
    exp_wr(base + 71, 2, 0, 0);
    at(base + 69);
    run = 1'b0;
    at(base + 90);
    check_log("wrap");

    // stop during NOTE: burst completes, MUTE follows directly
    base = cyc;
    run = 1'b1;
    at(base + 1);
    run = 1'b0;
    exp_wr(base + 2, 0, 3, 0);  exp_wr(base + 3, 2, 5, 0);  exp_wr(base + 4, 2, 0, 0);
    at(base + 25);
    check_log("notestop");
    chk("hold_addr", 32'(address), 32'd2);
    chk("hold_data", 32'(data), 32'd0);
    chk("notestop_busy", 32'(busy), 32'd0);

    // load collision on step-1 entry edge, tempo change mid-WAIT
    load(3'd0, 8'h84);
    load(3'd1, 8'h8B);
    vol_level = 4'd8;
    base = cyc;
    run = 1'b1;
    at(base + 8);
    load_en = 1'b1; load_addr = 3'd1; load_data = 8'h9E;
    at(base + 9);
    load_en = 1'b0;
    at(base + 13);
    tempo = 8'd3;
    exp_wr(base + 2, 0, 1, 0);   exp_wr(base + 3, 2, 8, 0);
    exp_wr(base + 10, 0, 2, 1);  exp_wr(base + 11, 2, 15, 1);
    exp_wr(base + 18, 0, 1, 0);  exp_wr(base + 19, 2, 8, 0);
    exp_wr(base + 34, 0, 7, 1);  exp_wr(base + 35, 2, 8, 1);
    exp_wr(base + 40, 2, 0, 0);
    at(base + 38);
    run = 1'b0;
    at(base + 60);
    check_log("collide");

    // reset mid-burst: no VOL, no MUTE, memory cleared
    tempo = 8'd1;
    base = cyc;
    run = 1'b1;
    at(base + 2);
    rst = 1'b0;
    at(base + 3);
    chk("midrst_strobe", 32'(write_strobe), 32'd0);
    chk("midrst_addr",   32'(address), 32'd0);
    chk("midrst_data",   32'(data), 32'd0);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_state",  32'(dbg_state), 32'd0);
    rst = 1'b1;
    exp_wr(base + 2, 0, 1, 0);
    exp_wr(base + 5, 0, 0, 0);  exp_wr(base + 6, 2, 0, 0);  exp_wr(base + 10, 2, 0, 0);
    at(base + 8);
    run = 1'b0;
    at(base + 30);
    check_log("midrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
